vector_sum_reduce: RTL
======================

// Module: vector_sum_reduce
// PURPOSE
//   Downstream of the element-wise vector multiplier. Accepts one packed product vector
//   of DIM elements and serially sums them into one overflow-free scalar (the dot product).
//   One element is added per cycle. Valid/ready handshakes on both sides give the
//   matrix-multiply datapath backpressure.
// PARAMETERS
//   DIM    10  number of elements per input vector (>=1)
//   W_P    64  bit-width of each product element (W_u+W_v of the multiplier)
//   W_OUT  derived localparam = W_P + $clog2(DIM); sum width, cannot overflow
// PORTS
//   Clock      in   1          single clock, all state updates on posedge
//   Reset      in   1          synchronous, active-high
//   in_vec     in   DIM*W_P    packed products; element k = in_vec[W_P*k +: W_P]
//   in_valid   in   1          in_vec valid
//   in_ready   out  1          block can accept a vector this cycle
//   out_sum    out  W_OUT      sum of the DIM elements, unsigned
//   out_valid  out  1          out_sum valid
//   out_ready  in   1          consumer accepts out_sum
// BEHAVIOUR
//   - Arithmetic: all elements unsigned, zero-extended to W_OUT. Sum is exact, no wrap.
//   - Reset (sync, high): state<=IDLE, acc<=0, idx<=0, out_valid<=0, out_sum<=0.
//     in_ready=0 while Reset is high, 1 on the first cycle after Reset falls.
//   - FSM states: IDLE, ACCUM, DONE. in_ready = (state==IDLE) && !Reset.
//   - IDLE: on posedge with in_valid&&in_ready: latch in_vec into internal buffer,
//     acc<=0, idx<=0, go ACCUM. Otherwise stay.
//   - ACCUM: each posedge acc<=acc+buf[idx], idx<=idx+1. On the edge where idx==DIM-1:
//     out_sum<=acc+buf[DIM-1], out_valid<=1, go DONE. ACCUM lasts exactly DIM cycles.
//   - DONE: out_valid=1 and out_sum held stable until out_ready. On posedge with
//     out_valid&&out_ready: out_valid<=0, go IDLE. out_sum keeps its last value afterwards.
//   - Latency: vector accepted at edge N gives out_valid high after edge N+DIM.
//   - Throughput with out_ready tied high: one vector per DIM+2 cycles.
//   - in_valid while busy (ACCUM/DONE) is ignored; no capture. Upstream must hold in_vec.
//   - The internal buffer isolates computation from in_vec changes after capture.
//   - DIM==1: ACCUM lasts one cycle. idx register width is max(1,$clog2(DIM)).
//   - Reset mid-ACCUM or mid-DONE: the partial result is discarded, no out_valid pulse,
//     and the next accepted vector sums from zero.
//   - out_valid never asserts combinationally from in_valid. All outputs except
//     in_ready are registered.
// TESTING
//   1 DIM=4,W_P=8: in_vec elems {1,2,3,4}, accept at edge 0 -> out_valid after edge 4,
//     out_sum=10.
//   2 Overflow: elems all 8'hFF (DIM=4) -> out_sum=10'd1020, W_OUT=10.
//   3 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_sum/out_valid stable,
//     in_ready=0. Release -> IDLE next cycle, in_ready=1.
//   4 Busy input: pulse in_valid with elems {9,9,9,9} during ACCUM of {1,2,3,4}
//     -> ignored, result still 10, no second out_valid.
//   5 Reset at 2nd ACCUM cycle, then send {5,5,5,5} -> single result 20,
//     no stale out_valid.
//   6 Back-to-back, out_ready=1, in_valid=1 for 3 vectors -> results 6 cycles apart
//     (DIM+2). DIM=1 variant: elem 7 -> out_sum=7 after 1 cycle.

Source files
------------

// File: rtl/vector_sum_reduce.sv
// Serial dot-product reducer: captures one packed vector of DIM unsigned products and
// adds one element per cycle into an overflow-free sum, with valid/ready on both sides.
module vector_sum_reduce #(
  parameter int DIM = 10,
  parameter int W_P = 64
) (
  input  logic                                  Clock,
  input  logic                                  Reset,
  input  logic [DIM*W_P-1:0]                    in_vec,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [W_P+$clog2(DIM)-1:0]            out_sum,
  output logic                                  out_valid,
  input  logic                                  out_ready
);

  localparam int W_OUT = W_P + $clog2(DIM);
  localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIM - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             state, state_nxt;
  logic [DIM*W_P-1:0] vec_buf;
  logic [W_OUT-1:0]   acc;
  logic [IDX_W-1:0]   idx;
  logic [W_P-1:0]     elem;
  logic [W_OUT-1:0]   acc_nxt;
  logic               accept;
  logic               last;

  function automatic logic [W_OUT-1:0] zext(input logic [W_P-1:0] e);
    return W_OUT'(e);
  endfunction

  assign in_ready = (state == IDLE) && !Reset;
  assign accept   = in_valid && in_ready;
  assign last     = (idx == IDX_LAST);
  assign elem     = vec_buf[W_P*idx +: W_P];
  assign acc_nxt  = acc + zext(elem);

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACCUM;
      ACCUM:   if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture into vec_buf so upstream may change in_vec after the handshake
  always_ff @(posedge Clock) begin
    if (Reset) begin
      acc       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            vec_buf <= in_vec;
            acc     <= '0;
            idx     <= '0;
          end
        end
        ACCUM: begin
          acc <= acc_nxt;
          idx <= idx + 1'b1;
          if (last) begin
            out_sum   <= acc_nxt;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
